// File: rtl/uncache_axi_master_if.sv
// Bus bundle for uncache_axi_master: the CPU SRAM-style request side plus the
// AXI read/write channels. The fixed AXI fields (len, burst, lock, cache, prot,
// wlast, ids) are tied off by the enclosing top level and do not appear here.
//   master : view of the uncache block (drives AXI requests and CPU responses)
//   slave  : view of the environment (CPU requester + AXI slave)
interface uncache_axi_master_if;
   // CPU request side
   logic [31:0] inst_addr;
   logic        inst_ren;
   logic        inst_valid;
   logic [31:0] inst_rd;
   logic [31:0] data_addr;
   logic        data_ren;
   logic [3:0]  data_wen;
   logic [31:0] data_wd;
   logic        data_valid;
   logic [31:0] data_rd;
   logic        is_cache;
   // AXI read channels
   logic [31:0] araddr;
   logic [2:0]  arsize;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic        rvalid;
   logic        rready;
   // AXI write channels
   logic [31:0] awaddr;
   logic [2:0]  awsize;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic        bvalid;
   logic        bready;

   modport master (
      input  inst_addr, inst_ren, data_addr, data_ren, data_wen, data_wd, is_cache,
             arready, rdata, rvalid, awready, wready, bvalid,
      output inst_valid, inst_rd, data_valid, data_rd,
             araddr, arsize, arvalid, rready, awaddr, awsize, awvalid,
             wdata, wstrb, wvalid, bready
   );

   modport slave (
      output inst_addr, inst_ren, data_addr, data_ren, data_wen, data_wd, is_cache,
             arready, rdata, rvalid, awready, wready, bvalid,
      input  inst_valid, inst_rd, data_valid, data_rd,
             araddr, arsize, arvalid, rready, awaddr, awsize, awvalid,
             wdata, wstrb, wvalid, bready
   );
endinterface

// File: rtl/uncache_axi_master.sv
// Uncached single-word AXI master. Takes inst/data requests with is_cache==0
// and issues one single-beat AXI transaction per request, then returns a
// one-cycle inst_valid/data_valid pulse. All AXI outputs are registered.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-low reset
//   bus  - uncache_axi_master_if.master (CPU request side + AXI channels)
// Parameters:
//   INST_SIZE - arsize used for instruction reads
// Optional build macro:
//   UNCACHE_WBUF_EN - posted writes: data_valid after AW+W, B collected in
//                     the background; new requests wait until B arrives.
module uncache_axi_master #(
   parameter logic [2:0] INST_SIZE = 3'd2
) (
   input  logic                 clk,
   input  logic                 rst,
   uncache_axi_master_if.master bus
);
   typedef enum logic [2:0] {S_IDLE, S_RD_ADDR, S_RD_DATA, S_WR_REQ, S_WR_RESP, S_DONE} state_t;

   state_t      r_state, w_state;
   logic        r_src_data, w_src_data;   // 1: data port owns the transaction
   logic [31:0] r_araddr, w_araddr;
   logic [2:0]  r_arsize, w_arsize;
   logic        r_arvalid, w_arvalid;
   logic        r_rready, w_rready;
   logic [31:0] r_awaddr, w_awaddr;
   logic [2:0]  r_awsize, w_awsize;
   logic        r_awvalid, w_awvalid;
   logic [31:0] r_wdata, w_wdata;
   logic [3:0]  r_wstrb, w_wstrb;
   logic        r_wvalid, w_wvalid;
   logic        r_bready, w_bready;
   logic        r_inst_valid, w_inst_valid;
   logic        r_data_valid, w_data_valid;
   logic [31:0] r_inst_rd, w_inst_rd;
   logic [31:0] r_data_rd, w_data_rd;
   logic [1:0]  w_wr_off;
   logic [2:0]  w_wr_size;
   logic        w_aw_done, w_w_done;

   // Narrow writes are expressed as size + byte offset derived from the strobes.
   always_comb begin
      w_wr_off  = 2'd0;
      w_wr_size = 3'd2;
      case (bus.data_wen)
         4'b0001: begin w_wr_off = 2'd0; w_wr_size = 3'd0; end
         4'b0010: begin w_wr_off = 2'd1; w_wr_size = 3'd0; end
         4'b0100: begin w_wr_off = 2'd2; w_wr_size = 3'd0; end
         4'b1000: begin w_wr_off = 2'd3; w_wr_size = 3'd0; end
         4'b0011: begin w_wr_off = 2'd0; w_wr_size = 3'd1; end
         4'b1100: begin w_wr_off = 2'd2; w_wr_size = 3'd1; end
         default: begin w_wr_off = 2'd0; w_wr_size = 3'd2; end
      endcase
   end

   // A channel counts as done if it already handshook or handshakes now.
   assign w_aw_done = !r_awvalid || bus.awready;
   assign w_w_done  = !r_wvalid  || bus.wready;

   always_comb begin
      w_state      = r_state;
      w_src_data   = r_src_data;
      w_araddr     = r_araddr;
      w_arsize     = r_arsize;
      w_arvalid    = r_arvalid;
      w_rready     = r_rready;
      w_awaddr     = r_awaddr;
      w_awsize     = r_awsize;
      w_awvalid    = r_awvalid;
      w_wdata      = r_wdata;
      w_wstrb      = r_wstrb;
      w_wvalid     = r_wvalid;
      w_bready     = r_bready;
      w_inst_valid = 1'b0;
      w_data_valid = 1'b0;
      w_inst_rd    = r_inst_rd;
      w_data_rd    = r_data_rd;

      // B acceptance is state-independent so a posted write can retire in IDLE.
      if (r_bready && bus.bvalid) w_bready = 1'b0;

      case (r_state)
         S_IDLE: begin
            // r_bready high here means a posted write still owes its B.
            if (!bus.is_cache && !r_bready) begin
               if (bus.data_ren) begin
                  w_src_data = 1'b1;
                  w_araddr   = bus.data_addr;
                  w_arsize   = 3'd2;
                  w_arvalid  = 1'b1;
                  w_state    = S_RD_ADDR;
               end else if (|bus.data_wen) begin
                  w_src_data = 1'b1;
                  w_awaddr   = {bus.data_addr[31:2], w_wr_off};
                  w_awsize   = w_wr_size;
                  w_wdata    = bus.data_wd;
                  w_wstrb    = bus.data_wen;
                  w_awvalid  = 1'b1;
                  w_wvalid   = 1'b1;
                  w_state    = S_WR_REQ;
               end else if (bus.inst_ren) begin
                  w_src_data = 1'b0;
                  w_araddr   = bus.inst_addr;
                  w_arsize   = INST_SIZE;
                  w_arvalid  = 1'b1;
                  w_state    = S_RD_ADDR;
               end
            end
         end
         S_RD_ADDR: begin
            if (r_arvalid && bus.arready) begin
               w_arvalid = 1'b0;
               w_rready  = 1'b1;
               w_state   = S_RD_DATA;
            end
         end
         S_RD_DATA: begin
            if (r_rready && bus.rvalid) begin
               w_rready = 1'b0;
               if (r_src_data) begin
                  w_data_rd    = bus.rdata;
                  w_data_valid = 1'b1;
               end else begin
                  w_inst_rd    = bus.rdata;
                  w_inst_valid = 1'b1;
               end
               w_state = S_DONE;
            end
         end
         S_WR_REQ: begin
            if (r_awvalid && bus.awready) w_awvalid = 1'b0;
            if (r_wvalid && bus.wready)   w_wvalid  = 1'b0;
            if (w_aw_done && w_w_done) begin
               w_bready = 1'b1;
`ifdef UNCACHE_WBUF_EN
               w_data_valid = 1'b1;
               w_state      = S_DONE;
`else
               w_state      = S_WR_RESP;
`endif
            end
         end
         S_WR_RESP: begin
            if (r_bready && bus.bvalid) begin
               w_data_valid = 1'b1;
               w_state      = S_DONE;
            end
         end
         S_DONE:  w_state = S_IDLE;
         default: w_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state      <= S_IDLE;
         r_src_data   <= 1'b0;
         r_araddr     <= '0;
         r_arsize     <= '0;
         r_arvalid    <= 1'b0;
         r_rready     <= 1'b0;
         r_awaddr     <= '0;
         r_awsize     <= '0;
         r_awvalid    <= 1'b0;
         r_wdata      <= '0;
         r_wstrb      <= '0;
         r_wvalid     <= 1'b0;
         r_bready     <= 1'b0;
         r_inst_valid <= 1'b0;
         r_data_valid <= 1'b0;
         r_inst_rd    <= '0;
         r_data_rd    <= '0;
      end else begin
         r_state      <= w_state;
         r_src_data   <= w_src_data;
         r_araddr     <= w_araddr;
         r_arsize     <= w_arsize;
         r_arvalid    <= w_arvalid;
         r_rready     <= w_rready;
         r_awaddr     <= w_awaddr;
         r_awsize     <= w_awsize;
         r_awvalid    <= w_awvalid;
         r_wdata      <= w_wdata;
         r_wstrb      <= w_wstrb;
         r_wvalid     <= w_wvalid;
         r_bready     <= w_bready;
         r_inst_valid <= w_inst_valid;
         r_data_valid <= w_data_valid;
         r_inst_rd    <= w_inst_rd;
         r_data_rd    <= w_data_rd;
      end
   end

   assign bus.araddr     = r_araddr;
   assign bus.arsize     = r_arsize;
   assign bus.arvalid    = r_arvalid;
   assign bus.rready     = r_rready;
   assign bus.awaddr     = r_awaddr;
   assign bus.awsize     = r_awsize;
   assign bus.awvalid    = r_awvalid;
   assign bus.wdata      = r_wdata;
   assign bus.wstrb      = r_wstrb;
   assign bus.wvalid     = r_wvalid;
   assign bus.bready     = r_bready;
   assign bus.inst_valid = r_inst_valid;
   assign bus.data_valid = r_data_valid;
   assign bus.inst_rd    = r_inst_rd;
   assign bus.data_rd    = r_data_rd;
endmodule

// File: tb/tb_uncache_axi_master.sv
// Directed bench for uncache_axi_master: table of single transactions plus
// hand-written sequences (priority, split AW/W handshake, cache bypass,
// mid-transaction reset, slow B response).
module tb_uncache_axi_master;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   uncache_axi_master_if bus ();

   uncache_axi_master #(.INST_SIZE(3'd2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int total = 0;
   int bad   = 0;

   typedef struct {
      bit          wr;
      bit          inst;
      logic [3:0]  wen;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] rd;
      logic [31:0] exp_addr;
      logic [2:0]  exp_size;
   } vec_t;

`ifdef UNCACHE_WBUF_EN
   localparam int WR_LAT = 2;
`else
   localparam int WR_LAT = 3;
`endif

   // monitor / slave state (n = negedges since the request was driven)
   int          n;
   logic [31:0] ar_q[$];
   logic [31:0] arsz_q[$];
   logic [31:0] aw_addr_c, wdata_c;
   logic [2:0]  aw_size_c;
   logic [3:0]  wstrb_c;
   int          iv_cnt, dv_cnt, iv_n, dv_n, ar_n, bready_n, awv_last_n, wv_last_n, b_hs_n;
   int          ar_dly, r_dly, aw_dly, w_dly, b_dly;
   int          ar_c, r_c, aw_c, w_c, b_c;
   logic [31:0] rdata_val;
   logic        p_arvalid, p_awvalid, p_bready;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] q_at(input logic [31:0] q[$], input int i);
      return (i < q.size()) ? q[i] : 32'hFFFF_FFFF;
   endfunction

   task automatic clear_log();
      n = 0; ar_q.delete(); arsz_q.delete();
      aw_addr_c = '1; wdata_c = '1; aw_size_c = '1; wstrb_c = '1;
      iv_cnt = 0; dv_cnt = 0; iv_n = -1; dv_n = -1; ar_n = -1; bready_n = -1;
      awv_last_n = -1; wv_last_n = -1; b_hs_n = -1;
      ar_dly = 0; r_dly = 0; aw_dly = 0; w_dly = 0; b_dly = 0;
   endtask

   task automatic drop_reqs();
      bus.inst_ren = 1'b0; bus.data_ren = 1'b0; bus.data_wen = 4'b0000;
   endtask

   // One cycle: sample DUT at negedge, then drive the slave for the next edge.
   task automatic cyc_step();
      @(negedge clk);
      n++;
      if (bus.arvalid && !p_arvalid) begin
         ar_q.push_back(bus.araddr); arsz_q.push_back({29'd0, bus.arsize}); ar_n = n;
      end
      if (bus.awvalid && !p_awvalid) begin
         aw_addr_c = bus.awaddr; aw_size_c = bus.awsize; wstrb_c = bus.wstrb; wdata_c = bus.wdata;
      end
      if (bus.awvalid) awv_last_n = n;
      if (bus.wvalid)  wv_last_n  = n;
      if (bus.bready && !p_bready) bready_n = n;
      if (bus.inst_valid) begin iv_cnt++; iv_n = n; end
      if (bus.data_valid) begin dv_cnt++; dv_n = n; end
      p_arvalid = bus.arvalid; p_awvalid = bus.awvalid; p_bready = bus.bready;
      bus.arready = bus.arvalid && (ar_c >= ar_dly);
      ar_c = bus.arvalid ? ar_c + 1 : 0;
      bus.rvalid = bus.rready && (r_c >= r_dly);
      bus.rdata  = bus.rvalid ? rdata_val : 32'hDEAD_BEEF;
      r_c = bus.rready ? r_c + 1 : 0;
      bus.awready = bus.awvalid && (aw_c >= aw_dly);
      aw_c = bus.awvalid ? aw_c + 1 : 0;
      bus.wready = bus.wvalid && (w_c >= w_dly);
      w_c = bus.wvalid ? w_c + 1 : 0;
      bus.bvalid = bus.bready && (b_c >= b_dly);
      if (bus.bvalid && b_hs_n < 0) b_hs_n = n;
      b_c = bus.bready ? b_c + 1 : 0;
   endtask

   task automatic wait_valid(input bit is_data, input int budget, input string nm);
      for (int k = 0; k < budget && (is_data ? dv_cnt : iv_cnt) == 0; k++) cyc_step();
      chk({nm, "_timeout"}, (is_data ? dv_cnt : iv_cnt) != 0, 1);
   endtask

   task automatic run_vec(input vec_t v, input string nm);
      clear_log();
      rdata_val = v.rd;
      if (v.wr) begin
         bus.data_addr = v.addr; bus.data_wd = v.wd; bus.data_wen = v.wen;
      end else if (v.inst) begin
         bus.inst_addr = v.addr; bus.inst_ren = 1'b1;
      end else begin
         bus.data_addr = v.addr; bus.data_ren = 1'b1;
      end
      wait_valid(!v.inst, 40, nm);
      drop_reqs();
      cyc_step(); cyc_step(); cyc_step();
      if (v.wr) begin
         chk({nm, "_awaddr"}, aw_addr_c, v.exp_addr);
         chk({nm, "_awsize"}, {29'd0, aw_size_c}, {29'd0, v.exp_size});
         chk({nm, "_wstrb"}, {28'd0, wstrb_c}, {28'd0, v.wen});
         chk({nm, "_wdata"}, wdata_c, v.wd);
         chk({nm, "_lat"}, dv_n, WR_LAT);
      end else begin
         chk({nm, "_araddr"}, q_at(ar_q, 0), v.exp_addr);
         chk({nm, "_arsize"}, q_at(arsz_q, 0), {29'd0, v.exp_size});
         chk({nm, "_rd"}, v.inst ? bus.inst_rd : bus.data_rd, v.rd);
         chk({nm, "_lat"}, v.inst ? iv_n : dv_n, 3);
      end
      chk({nm, "_pulses"}, iv_cnt + dv_cnt, 1);
      chk({nm, "_src"}, v.inst ? iv_cnt : dv_cnt, 1);
   endtask

   vec_t vecs[10];

   initial begin
      bus.inst_addr = '0; bus.inst_ren = 1'b0; bus.data_addr = '0; bus.data_ren = 1'b0;
      bus.data_wen = '0; bus.data_wd = '0; bus.is_cache = 1'b0;
      bus.arready = 1'b0; bus.rdata = '0; bus.rvalid = 1'b0;
      bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0;
      p_arvalid = 1'b0; p_awvalid = 1'b0; p_bready = 1'b0;
      ar_c = 0; r_c = 0; aw_c = 0; w_c = 0; b_c = 0; rdata_val = '0;
      clear_log();

      //            wr  inst wen      addr           wd             rd             exp_addr       size
      vecs[0] = '{1'b0, 1'b1, 4'b0000, 32'h1FC0_0000, 32'h0,         32'h3C1D_BFC0, 32'h1FC0_0000, 3'd2};
      vecs[1] = '{1'b0, 1'b0, 4'b0000, 32'h1FAF_0010, 32'h0,         32'h1234_5678, 32'h1FAF_0010, 3'd2};
      vecs[2] = '{1'b1, 1'b0, 4'b0100, 32'h1FAF_0001, 32'h00AB_0000, 32'h0,         32'h1FAF_0002, 3'd0};
      vecs[3] = '{1'b1, 1'b0, 4'b0001, 32'h0000_1003, 32'h0000_0011, 32'h0,         32'h0000_1000, 3'd0};
      vecs[4] = '{1'b1, 1'b0, 4'b0010, 32'h0000_1000, 32'h0000_2200, 32'h0,         32'h0000_1001, 3'd0};
      vecs[5] = '{1'b1, 1'b0, 4'b1000, 32'h0000_2000, 32'h4400_0000, 32'h0,         32'h0000_2003, 3'd0};
      vecs[6] = '{1'b1, 1'b0, 4'b0011, 32'h0000_3002, 32'h0000_BEEF, 32'h0,         32'h0000_3000, 3'd1};
      vecs[7] = '{1'b1, 1'b0, 4'b1100, 32'h0000_4000, 32'hCAFE_0000, 32'h0,         32'h0000_4002, 3'd1};
      vecs[8] = '{1'b1, 1'b0, 4'b1111, 32'h0000_5003, 32'h0102_0304, 32'h0,         32'h0000_5000, 3'd2};
      vecs[9] = '{1'b0, 1'b1, 4'b0000, 32'hBFC0_0380, 32'h0,         32'h2408_0001, 32'hBFC0_0380, 3'd2};

      // reset state
      cyc_step(); cyc_step();
      chk("rst_ctl", {25'd0, bus.arvalid, bus.rready, bus.awvalid, bus.wvalid,
                      bus.bready, bus.inst_valid, bus.data_valid}, 32'd0);
      chk("rst_araddr", bus.araddr, 32'd0);
      chk("rst_awaddr", bus.awaddr, 32'd0);
      chk("rst_wdata", bus.wdata, 32'd0);
      chk("rst_rd", bus.inst_rd | bus.data_rd, 32'd0);
      chk("rst_sz_strb", {22'd0, bus.arsize, bus.awsize, bus.wstrb}, 32'd0);
      rst = 1'b1;
      cyc_step();

      foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

      // data read and inst read together: data goes first
      clear_log();
      bus.data_addr = 32'h1FAF_0100; bus.data_ren = 1'b1;
      bus.inst_addr = 32'h1FC0_0040; bus.inst_ren = 1'b1;
      rdata_val = 32'hAAAA_5555;
      wait_valid(1'b1, 40, "prio_d");
      bus.data_ren = 1'b0;
      chk("prio_first_addr", q_at(ar_q, 0), 32'h1FAF_0100);
      chk("prio_no_inst_yet", iv_cnt, 0);
      chk("prio_drd", bus.data_rd, 32'hAAAA_5555);
      rdata_val = 32'h5555_AAAA;
      wait_valid(1'b0, 40, "prio_i");
      bus.inst_ren = 1'b0;
      chk("prio_second_addr", q_at(ar_q, 1), 32'h1FC0_0040);
      chk("prio_order", iv_n > dv_n, 1);
      chk("prio_ird", bus.inst_rd, 32'h5555_AAAA);
      cyc_step(); cyc_step();
      chk("prio_pulses", iv_cnt + dv_cnt, 2);

      // awready immediate, wready three cycles late
      clear_log();
      w_dly = 3;
      bus.data_addr = 32'h0000_6000; bus.data_wd = 32'h1111_2222; bus.data_wen = 4'b1111;
      wait_valid(1'b1, 40, "split");
      drop_reqs();
      cyc_step(); cyc_step(); cyc_step();
      chk("split_aw_last", awv_last_n, 1);
      chk("split_w_last", wv_last_n, 4);
      chk("split_bready", bready_n, 5);
      chk("split_pulses", dv_cnt, 1);

      // is_cache==1 requests are ignored
      clear_log();
      bus.is_cache = 1'b1; bus.inst_addr = 32'h0000_7000; bus.inst_ren = 1'b1;
      rdata_val = 32'h0BAD_F00D;
      for (int k = 0; k < 6; k++) cyc_step();
      chk("cache_no_ar", ar_q.size(), 0);
      chk("cache_no_valid", iv_cnt + dv_cnt, 0);
      bus.is_cache = 1'b0;
      wait_valid(1'b0, 40, "cache_off");
      bus.inst_ren = 1'b0;
      chk("cache_off_rd", bus.inst_rd, 32'h0BAD_F00D);
      cyc_step(); cyc_step();

      // reset while waiting in RD_DATA
      clear_log();
      r_dly = 5;
      bus.inst_addr = 32'h1FC0_0100; bus.inst_ren = 1'b1;
      for (int k = 0; k < 20 && !bus.rready; k++) cyc_step();
      chk("mid_rready", bus.rready, 1);
      rst = 1'b0; bus.inst_ren = 1'b0;
      cyc_step();
      chk("mid_ctl", {25'd0, bus.arvalid, bus.rready, bus.awvalid, bus.wvalid,
                      bus.bready, bus.inst_valid, bus.data_valid}, 32'd0);
      rst = 1'b1;
      for (int k = 0; k < 8; k++) cyc_step();
      chk("mid_no_pulse", iv_cnt + dv_cnt, 0);
      chk("mid_one_ar", ar_q.size(), 1);
      run_vec(vecs[0], "after_rst");

      // slow B response followed by a data read
      clear_log();
      b_dly = 10;
      bus.data_addr = 32'h0000_8000; bus.data_wd = 32'h7777_8888; bus.data_wen = 4'b1111;
      wait_valid(1'b1, 40, "slowb_w");
      drop_reqs();
`ifdef UNCACHE_WBUF_EN
      chk("slowb_posted_lat", dv_n, 2);
      chk("slowb_b_pending", b_hs_n, -1);
`else
      chk("slowb_after_b", dv_n > b_hs_n && b_hs_n > 0, 1);
`endif
      dv_cnt = 0;
      rdata_val = 32'h9999_0000;
      bus.data_addr = 32'h0000_8004; bus.data_ren = 1'b1;
      wait_valid(1'b1, 60, "slowb_r");
      bus.data_ren = 1'b0;
      chk("slowb_ar_after_b", ar_n > b_hs_n && b_hs_n > 0, 1);
      chk("slowb_ar_addr", q_at(ar_q, 0), 32'h0000_8004);
      chk("slowb_rd", bus.data_rd, 32'h9999_0000);
      cyc_step(); cyc_step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/uncache_axi_master.md
Name: uncache_axi_master

Overview:
Uncached single-word AXI master directly downstream of the CPU SRAM-style request interface. It consumes inst/data read and write requests whose is_cache is 0 and issues one single-beat AXI transaction per request (len=0, INCR). It returns a one-cycle valid pulse with read data to the requester. Fixed AXI fields (len, burst, lock, cache, prot, wlast=1, ids) are tied off at top level.

Parameters:
INST_SIZE, 3'd2, arsize used for instruction reads (word)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-low reset
inst_addr  in  32  physical instruction address
inst_ren  in  1  instruction read request (level, held until inst_valid)
inst_valid  out  1  one-cycle pulse: inst_rd valid
inst_rd  out  32  instruction read data
data_addr  in  32  physical data address
data_ren  in  1  data read request (level, held until data_valid)
data_wen  in  4  data byte write enables; nonzero = write request
data_wd  in  32  data write data
data_valid  out  1  one-cycle pulse: data read/write complete
data_rd  out  32  data read data
is_cache  in  1  0 = request belongs to this block
araddr  out  32  AXI read address
arsize  out  3  AXI read size
arvalid  out  1  AXI read address valid
arready  in  1  AXI read address ready
rdata  in  32  AXI read data
rvalid  in  1  AXI read data valid
rready  out  1  AXI read data ready
awaddr  out  32  AXI write address
awsize  out  3  AXI write size
awvalid  out  1  AXI write address valid
awready  in  1  AXI write address ready
wdata  out  32  AXI write data
wstrb  out  4  AXI write strobes
wvalid  out  1  AXI write data valid
wready  in  1  AXI write data ready
bvalid  in  1  AXI write response valid
bready  out  1  AXI write response ready

Behaviour:
- Reset (rst==0 at clk edge): state IDLE; all valid/ready outputs 0; araddr, awaddr, wdata, inst_rd, data_rd 0; wstrb 0; sizes 0. Reset mid-transaction abandons it: no valid pulse is produced, and AXI outputs drop immediately.
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE. Every AXI output is registered.
- IDLE, is_cache==0, priority data_ren > data_wen!=0 > inst_ren: latch addr, wdata and strobes, plus source (inst/data). Next cycle enter RD_ADDR with arvalid=1, or WR_REQ with awvalid=wvalid=1. Requests with is_cache==1 are ignored.
- RD_ADDR: hold araddr/arsize until arvalid&&arready, then arvalid=0, rready=1, go RD_DATA. Data reads use arsize=2.
- RD_DATA: on rvalid&&rready, latch rdata into inst_rd or data_rd, rready=0, go DONE. rresp is ignored.
- WR_REQ: awvalid and wvalid drop independently on their own handshake (same or different cycles). When both are done, bready=1 and go WR_RESP. bresp is ignored.
- WR_RESP: on bvalid, bready=0, go DONE.
- DONE: pulse inst_valid or data_valid for exactly one cycle, then IDLE. Read data stays stable until the next read of the same source.
- Minimum latency with ready/valid responding at once: request sampled at N, arvalid at N+1, rvalid at N+2, data_valid at N+3.
- awsize/awaddr from wen: 0001/0010/0100/1000 -> size 0, addr[1:0]=0/1/2/3. 0011 -> size 1, addr[1:0]=0. 1100 -> size 1, addr[1:0]=2. 1111 -> size 2, addr[1:0]=0. wstrb=wen. Other patterns -> size 2.
- One transaction outstanding; requests arriving while busy wait. Since the requester holds ren, a request re-asserted in the DONE cycle is sampled in the following IDLE.

Optional Feature:
UNCACHE_WBUF_EN: posted writes. With it, data_valid for a write pulses once both AW and W handshakes complete (state goes straight to DONE). B is then collected in the background with bready=1. Any new request waits in IDLE until that outstanding B is received, preserving ordering. Without it, data_valid waits for bvalid.

Test Plan:
- inst_ren=1, inst_addr=0x1FC00000, is_cache=0; arready, rvalid immediate, rdata=0x3C1DBFC0 -> araddr=0x1FC00000, arsize=2; inst_valid one cycle at N+3; inst_rd=0x3C1DBFC0.
- data_ren and inst_ren both high, same cycle -> AR uses data_addr first; data_valid precedes the inst transaction; no inst_valid before it.
- data_wen=0100, addr=0x1FAF0001, wd=0x00AB0000 -> awaddr=0x1FAF0002, awsize=0, wstrb=0100, wdata=0x00AB0000; data_valid after bvalid.
- awready at N+1, wready delayed to N+4 -> awvalid drops after N+1, wvalid held to N+4, bready rises N+5; exactly one data_valid pulse.
- rst=0 while in RD_DATA -> next cycle all valids/readies 0, no inst_valid/data_valid pulse; a fresh read afterwards completes normally.
- UNCACHE_WBUF_EN: write with bvalid delayed 10 cycles, then data_ren -> data_valid for the write right after AW/W; arvalid not raised until bvalid seen.
